// File: rtl/game_turn_controller.sv
// Two-player board-game turn sequencer: dice in, pixel targets out.
// Optional macro BONUS_TILE_EN: tiles 2/4/6/8 advance one extra tile.
module game_turn_controller #(
   parameter int TILE_X0    = 20,
   parameter int TILE_PITCH = 60,
   parameter int LAST_TILE  = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] dice_value,
   input  logic       dice_valid,
   input  logic       restart,
   input  logic       turn_done,
   output logic [9:0] player1_pos_x,
   output logic [9:0] player2_pos_x,
   output logic       pos_valid,
   output logic       active_player,
   output logic       winner_valid,
   output logic       winner_id,
   output logic       dice_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_WAIT_DONE,
      S_CHECK,
      S_WIN
   } state_t;

   localparam logic [4:0] LP_LAST = 5'(LAST_TILE);
   localparam logic [9:0] LP_X0   = 10'(TILE_X0);

   state_t     r_state;
   logic [2:0] r_dice;
   logic [4:0] r_tile1;
   logic [4:0] r_tile2;
   logic [9:0] r_p1_x;
   logic [9:0] r_p2_x;
   logic       r_pos_valid;
   logic       r_active;
   logic       r_win_valid;
   logic       r_win_id;
   logic       r_restart_flag;
   logic       r_dice_ready;

   logic [4:0] w_cur_tile;
   logic [4:0] w_sum;
   logic [4:0] w_clamp;
   logic [4:0] w_new_tile;
   logic       w_dice_ok;
   logic [9:0] w_x1;
   logic [9:0] w_x2;

   assign w_cur_tile = r_active ? r_tile2 : r_tile1;
   // 5-bit sum cannot wrap for any LAST_TILE up to 25
   assign w_sum      = w_cur_tile + {2'b00, r_dice};
   assign w_clamp    = (w_sum > LP_LAST) ? LP_LAST : w_sum;

`ifdef BONUS_TILE_EN
   logic w_bonus;
   assign w_bonus    = (w_clamp == 5'd2) || (w_clamp == 5'd4) ||
                       (w_clamp == 5'd6) || (w_clamp == 5'd8);
   assign w_new_tile = !w_bonus           ? w_clamp :
                       (w_clamp >= LP_LAST) ? LP_LAST :
                       w_clamp + 5'd1;
`else
   assign w_new_tile = w_clamp;
`endif

   assign w_dice_ok = (dice_value != 3'd0) && (dice_value != 3'd7);
   assign w_x1      = 10'(TILE_X0 + TILE_PITCH * int'(r_tile1));
   assign w_x2      = 10'(TILE_X0 + TILE_PITCH * int'(r_tile2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_dice         <= 3'd0;
         r_tile1        <= 5'd0;
         r_tile2        <= 5'd0;
         r_p1_x         <= LP_X0;
         r_p2_x         <= LP_X0;
         r_pos_valid    <= 1'b0;
         r_active       <= 1'b0;
         r_win_valid    <= 1'b0;
         r_win_id       <= 1'b0;
         r_restart_flag <= 1'b0;
         r_dice_ready   <= 1'b1;
      end else begin
         r_pos_valid <= 1'b0;
         if (restart) begin
            r_tile1        <= 5'd0;
            r_tile2        <= 5'd0;
            r_active       <= 1'b0;
            r_win_valid    <= 1'b0;
            r_restart_flag <= 1'b1;
            r_state        <= S_ISSUE;
            r_dice_ready   <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (dice_valid && w_dice_ok) begin
                     r_dice       <= dice_value;
                     r_state      <= S_CALC;
                     r_dice_ready <= 1'b0;
                  end
               end
               S_CALC: begin
                  if (r_active) r_tile2 <= w_new_tile;
                  else          r_tile1 <= w_new_tile;
                  r_state <= S_ISSUE;
               end
               S_ISSUE: begin
                  r_p1_x      <= w_x1;
                  r_p2_x      <= w_x2;
                  r_pos_valid <= 1'b1;
                  r_state     <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (turn_done) r_state <= S_CHECK;
               end
               S_CHECK: begin
                  // a restart turn only re-centres the pieces
                  if (r_restart_flag) begin
                     r_restart_flag <= 1'b0;
                     r_state        <= S_IDLE;
                     r_dice_ready   <= 1'b1;
                  end else if (w_cur_tile == LP_LAST) begin
                     r_win_id    <= r_active;
                     r_win_valid <= 1'b1;
                     r_state     <= S_WIN;
                  end else begin
                     r_active     <= ~r_active;
                     r_state      <= S_IDLE;
                     r_dice_ready <= 1'b1;
                  end
               end
               S_WIN: begin
                  r_state <= S_WIN;
               end
               default: begin
                  r_state      <= S_IDLE;
                  r_dice_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign player1_pos_x = r_p1_x;
   assign player2_pos_x = r_p2_x;
   assign pos_valid     = r_pos_valid;
   assign active_player = r_active;
   assign winner_valid  = r_win_valid;
   assign winner_id     = r_win_id;
   assign dice_ready    = r_dice_ready;

endmodule
